// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg
// Shared encodings for the multi-cycle CPU: opcodes, ALU operation codes,
// control-FSM states and the register-destination / write-back select
// encodings. Imported by the control unit, the datapath and the ALU.
package cpu_defs_pkg;

  // Opcodes (instr[31:27])
  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_ADDI = 5'b00110;
  localparam logic [4:0] OP_LW   = 5'b00111;
  localparam logic [4:0] OP_SW   = 5'b01000;
  localparam logic [4:0] OP_BEQ  = 5'b01001;
  localparam logic [4:0] OP_BNE  = 5'b01010;
  localparam logic [4:0] OP_JAL  = 5'b01011;
  localparam logic [4:0] OP_HALT = 5'b11111;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLT = 5'b00100;

  // Register-file destination select
  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_R7 = 2'b10;

  // Write-back source select
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  // Control FSM states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Datapath select fields held stable from EXEC through WB
  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_b;
    logic [4:0] alu_op;
  } ctrl_sel_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Purely combinational opcode decoder for the control FSM.
// Ports:
//   i_opcode     in   5  opcode to decode
//   o_sel        out     datapath select fields (reg_dst, mem_to_reg, src_b, alu op)
//   o_legal      out  1  opcode is defined (HALT counts as legal)
//   o_is_halt    out  1  HALT
//   o_is_mem     out  1  LW or SW (needs the MEM state)
//   o_is_lw      out  1  LW
//   o_is_sw      out  1  SW
//   o_is_branch  out  1  BEQ or BNE
//   o_is_bne     out  1  BNE (branch taken on zero = 0)
//   o_is_jal     out  1  JAL
//   o_reg_write  out  1  instruction writes the register file in WB
module ctrl_decode
  import cpu_defs_pkg::*;
(
  input  logic [4:0] i_opcode,
  output ctrl_sel_t  o_sel,
  output logic       o_legal,
  output logic       o_is_halt,
  output logic       o_is_mem,
  output logic       o_is_lw,
  output logic       o_is_sw,
  output logic       o_is_branch,
  output logic       o_is_bne,
  output logic       o_is_jal,
  output logic       o_reg_write
);

  always_comb begin
    o_sel       = '0;
    o_legal     = 1'b1;
    o_is_halt   = 1'b0;
    o_is_mem    = 1'b0;
    o_is_lw     = 1'b0;
    o_is_sw     = 1'b0;
    o_is_branch = 1'b0;
    o_is_bne    = 1'b0;
    o_is_jal    = 1'b0;
    o_reg_write = 1'b0;
    case (i_opcode)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        o_sel.reg_dst = RDST_RD;
        o_reg_write   = 1'b1;
        case (i_opcode)
          OP_SUB:  o_sel.alu_op = ALU_SUB;
          OP_AND:  o_sel.alu_op = ALU_AND;
          OP_OR:   o_sel.alu_op = ALU_OR;
          OP_SLT:  o_sel.alu_op = ALU_SLT;
          default: o_sel.alu_op = ALU_ADD;
        endcase
      end
      OP_ADDI: begin
        o_sel.reg_dst   = RDST_RT;
        o_sel.alu_src_b = 1'b1;
        o_sel.alu_op    = ALU_ADD;
        o_reg_write     = 1'b1;
      end
      OP_LW: begin
        o_sel.reg_dst    = RDST_RT;
        o_sel.alu_src_b  = 1'b1;
        o_sel.alu_op     = ALU_ADD;
        o_sel.mem_to_reg = M2R_MEM;
        o_is_mem         = 1'b1;
        o_is_lw          = 1'b1;
        o_reg_write      = 1'b1;
      end
      OP_SW: begin
        o_sel.alu_src_b = 1'b1;
        o_sel.alu_op    = ALU_ADD;
        o_is_mem        = 1'b1;
        o_is_sw         = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        o_sel.alu_op = ALU_SUB;
        o_is_branch  = 1'b1;
        o_is_bne     = (i_opcode == OP_BNE);
      end
      OP_JAL: begin
        o_sel.reg_dst    = RDST_R7;
        o_sel.mem_to_reg = M2R_PC4;
        o_is_jal         = 1'b1;
        o_reg_write      = 1'b1;
      end
      OP_HALT: o_is_halt = 1'b1;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Multi-cycle control unit: walks each instruction through
// FETCH/DECODE/EXEC/[MEM]/WB and drives the datapath control inputs.
// Ports:
//   clk            in   1      system clock, rising edge
//   rst            in   1      asynchronous active-low reset
//   run_en         in   1      FSM may leave FETCH only while high
//   opcode_in      in   5      datapath opcode_out
//   zero_flag_in   in   1      datapath zero_flag_out
//   pc_write_en    out  1      PC update strobe (WB only)
//   pc_src_sel     out  1      0 = PC+4, 1 = branch/jump target
//   reg_write_en   out  1      register-file write strobe (WB only)
//   mem_to_reg_sel out  2      write-back source select
//   mem_read_en    out  1      data-memory read enable (LW, MEM and WB)
//   mem_write_en   out  1      data-memory write strobe (SW, last MEM cycle)
//   alu_src_b_sel  out  1      0 = rt, 1 = sign-extended immediate
//   alu_control_op out  5      ALU operation code
//   reg_dst_in     out  2      register destination select
//   state_out      out  3      current state encoding
//   halted         out  1      high in S_HALT
//   illegal_op     out  1      sticky undefined-opcode flag
//   instr_retired  out  CNT_W  retired-instruction count (wraps)
module multicycle_control_fsm
  import cpu_defs_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic [4:0]       opcode_in,
  input  logic             zero_flag_in,
  output logic             pc_write_en,
  output logic             pc_src_sel,
  output logic             reg_write_en,
  output logic [1:0]       mem_to_reg_sel,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic             alu_src_b_sel,
  output logic [4:0]       alu_control_op,
  output logic [1:0]       reg_dst_in,
  output logic [2:0]       state_out,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [3:0] LP_MEM_LAST = 4'(MEM_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [4:0]       r_ir_op;
  ctrl_sel_t        r_sel;
  logic             r_zero;
  logic             r_illegal;
  logic [3:0]       r_mem_cnt;
  logic [CNT_W-1:0] r_retired;

  logic [4:0]       w_dec_op;
  ctrl_sel_t        w_sel;
  logic             w_legal, w_is_halt, w_is_mem, w_is_lw, w_is_sw;
  logic             w_is_branch, w_is_bne, w_is_jal, w_reg_write;
  logic             w_mem_last;
  logic             w_take;

  // In DECODE the opcode is not latched yet, so decode the live input;
  // every later state decodes the latched copy.
  assign w_dec_op = (r_state == S_DECODE) ? opcode_in : r_ir_op;

  ctrl_decode u_decode (
    .i_opcode    (w_dec_op),
    .o_sel       (w_sel),
    .o_legal     (w_legal),
    .o_is_halt   (w_is_halt),
    .o_is_mem    (w_is_mem),
    .o_is_lw     (w_is_lw),
    .o_is_sw     (w_is_sw),
    .o_is_branch (w_is_branch),
    .o_is_bne    (w_is_bne),
    .o_is_jal    (w_is_jal),
    .o_reg_write (w_reg_write)
  );

  assign w_mem_last = (r_mem_cnt == LP_MEM_LAST);
  // BEQ takes on zero, BNE on non-zero
  assign w_take     = w_is_jal | (w_is_branch & (r_zero ^ w_is_bne));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    pc_write_en  = 1'b0;
    pc_src_sel   = 1'b0;
    reg_write_en = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    case (r_state)
      S_FETCH:  if (run_en) w_next = S_DECODE;
      S_DECODE: w_next = (w_is_halt || !w_legal) ? S_HALT : S_EXEC;
      S_EXEC:   w_next = w_is_mem ? S_MEM : S_WB;
      S_MEM: begin
        mem_read_en  = w_is_lw;
        mem_write_en = w_is_sw & w_mem_last;
        if (w_mem_last) w_next = S_WB;
      end
      S_WB: begin
        pc_write_en  = 1'b1;
        pc_src_sel   = w_take;
        reg_write_en = w_reg_write;
        mem_read_en  = w_is_lw;
        w_next       = S_FETCH;
      end
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir_op   <= OP_NOP;
      r_sel     <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
      r_mem_cnt <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_DECODE: begin
          r_ir_op <= opcode_in;
          if (w_next == S_EXEC) r_sel <= w_sel;
          if (!w_legal) r_illegal <= 1'b1;
        end
        S_EXEC: r_zero <= zero_flag_in;
        S_MEM:  r_mem_cnt <= w_mem_last ? '0 : r_mem_cnt + 4'd1;
        S_WB: begin
          r_sel     <= '0;
          r_retired <= r_retired + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign reg_dst_in     = r_sel.reg_dst;
  assign mem_to_reg_sel = r_sel.mem_to_reg;
  assign alu_src_b_sel  = r_sel.alu_src_b;
  assign alu_control_op = r_sel.alu_op;
  assign state_out      = r_state;
  assign halted         = (r_state == S_HALT);
  assign illegal_op     = r_illegal;
  assign instr_retired  = r_retired;

endmodule
